// File: rtl/vermibus_router.sv
// rtl/vermibus_router.sv - N-way Vermicel data-bus router with error status, timeout and IRQ aggregation
module vermibus_router #(
  parameter int                       NUM_DEVICES    = 3,
  parameter logic [NUM_DEVICES*8-1:0] DEV_BASES      = {8'h81, 8'h80, 8'h00},
  parameter int                       TIMEOUT_CYCLES = 64,
  parameter logic [NUM_DEVICES-1:0]   IRQ_MASK       = '1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid,
  input  logic [31:0]              address,
  input  logic [3:0]               wstrobe,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     ready,
  output logic                     irq,
  output logic [NUM_DEVICES-1:0]   dev_valid,
  output logic [31:0]              dev_address,
  output logic [3:0]               dev_wstrobe,
  output logic [31:0]              dev_wdata,
  input  logic [NUM_DEVICES*32-1:0] dev_rdata,
  input  logic [NUM_DEVICES-1:0]   dev_ready,
  input  logic [NUM_DEVICES-1:0]   dev_irq,
  input  logic                     err_clear,
  output logic                     err_unmapped,
  output logic                     err_timeout,
  output logic [31:0]              err_address
);

  localparam int IDX_W = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   sel, sel_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               set_unmapped, set_timeout;
  logic               timeout_hit;
  logic [31:0]        rd_arr [NUM_DEVICES];

  assign dev_address = address;
  assign dev_wstrobe = wstrobe;
  assign dev_wdata   = wdata;
  assign irq         = |(dev_irq & IRQ_MASK);

  // Unpack per-device read data so it can be indexed by channel number
  always_comb begin
    for (int i = 0; i < NUM_DEVICES; i++) begin
      rd_arr[i] = dev_rdata[32*i +: 32];
    end
  end

  // Tag decode; scanning downward lets the lowest matching index win
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_DEVICES - 1; i >= 0; i--) begin
      if (DEV_BASES[8*i +: 8] == address[31:24]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES));

  // Next-state and host/device handshake outputs
  always_comb begin
    state_next   = state;
    sel_next     = sel;
    cnt_next     = cnt;
    dev_valid    = '0;
    ready        = 1'b0;
    rdata        = 32'h0;
    set_unmapped = 1'b0;
    set_timeout  = 1'b0;
    case (state)
      IDLE: begin
        if (valid) begin
          if (hit) begin
            dev_valid[hit_idx] = 1'b1;
            ready              = dev_ready[hit_idx];
            rdata              = rd_arr[hit_idx];
            if (!dev_ready[hit_idx]) begin
              state_next = BUSY;
              sel_next   = hit_idx;
              cnt_next   = CNT_W'(1);
            end
          end else begin
            // Unmapped tag: terminate immediately so the host never hangs
            ready        = 1'b1;
            set_unmapped = 1'b1;
          end
        end
      end
      BUSY: begin
        if (!valid) begin
          // Host abandoned the access; drop it quietly
          state_next = IDLE;
          cnt_next   = '0;
        end else if (dev_ready[sel]) begin
          dev_valid[sel] = 1'b1;
          ready          = 1'b1;
          rdata          = rd_arr[sel];
          state_next     = IDLE;
          cnt_next       = '0;
        end else if (timeout_hit) begin
          ready       = 1'b1;
          set_timeout = 1'b1;
          state_next  = IDLE;
          cnt_next    = '0;
        end else begin
          dev_valid[sel] = 1'b1;
          if (cnt != '1) cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM, channel select and stall counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sel   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      sel   <= sel_next;
      cnt   <= cnt_next;
    end
  end

  // Sticky error status; a new error takes priority over a clear
  always_ff @(posedge clk) begin
    if (reset) begin
      err_unmapped <= 1'b0;
      err_timeout  <= 1'b0;
      err_address  <= 32'h0;
    end else begin
      if (err_clear) begin
        err_unmapped <= 1'b0;
        err_timeout  <= 1'b0;
      end
      if (set_unmapped) err_unmapped <= 1'b1;
      if (set_timeout)  err_timeout  <= 1'b1;
      if (set_unmapped || set_timeout) err_address <= address;
    end
  end

endmodule

// File: tb/tb_vermibus_router.sv
// tb/tb_vermibus_router.sv - directed self-checking bench for vermibus_router
module tb_vermibus_router;

  logic        clk = 1'b0;
  logic        reset, valid, err_clear;
  logic [31:0] address, wdata;
  logic [3:0]  wstrobe;
  logic [95:0] dev_rdata;
  logic [2:0]  dev_ready, dev_irq;

  logic [31:0] rdata, dev_address, dev_wdata, err_address;
  logic        ready, irq, err_unmapped, err_timeout;
  logic [2:0]  dev_valid;
  logic [3:0]  dev_wstrobe;

  logic [31:0] d_rdata, d_dev_address, d_dev_wdata, d_err_address;
  logic        d_ready, d_irq, d_err_unmapped, d_err_timeout;
  logic [2:0]  d_dev_valid;
  logic [3:0]  d_dev_wstrobe;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vermibus_router #(
    .NUM_DEVICES(3), .DEV_BASES({8'h81, 8'h80, 8'h00}),
    .TIMEOUT_CYCLES(4), .IRQ_MASK(3'b010)
  ) u_dut (
    .clk(clk), .reset(reset), .valid(valid), .address(address),
    .wstrobe(wstrobe), .wdata(wdata), .rdata(rdata), .ready(ready),
    .irq(irq), .dev_valid(dev_valid), .dev_address(dev_address),
    .dev_wstrobe(dev_wstrobe), .dev_wdata(dev_wdata), .dev_rdata(dev_rdata),
    .dev_ready(dev_ready), .dev_irq(dev_irq), .err_clear(err_clear),
    .err_unmapped(err_unmapped), .err_timeout(err_timeout),
    .err_address(err_address)
  );

  vermibus_router #(
    .NUM_DEVICES(3), .DEV_BASES({8'h00, 8'h80, 8'h00}),
    .TIMEOUT_CYCLES(64), .IRQ_MASK(3'b111)
  ) u_dup (
    .clk(clk), .reset(reset), .valid(valid), .address(address),
    .wstrobe(wstrobe), .wdata(wdata), .rdata(d_rdata), .ready(d_ready),
    .irq(d_irq), .dev_valid(d_dev_valid), .dev_address(d_dev_address),
    .dev_wstrobe(d_dev_wstrobe), .dev_wdata(d_dev_wdata), .dev_rdata(dev_rdata),
    .dev_ready(dev_ready), .dev_irq(dev_irq), .err_clear(err_clear),
    .err_unmapped(d_err_unmapped), .err_timeout(d_err_timeout),
    .err_address(d_err_address)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; err_clear = 1'b0;
    address = 32'h0; wdata = 32'h0; wstrobe = 4'h0;
    dev_rdata = {32'hD00D_0003, 32'hBEEF_0002, 32'hCAFE_0001};
    dev_ready = 3'b000; dev_irq = 3'b000;
    tick(); tick();
    @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'h0);
    chk("rst_dev_valid", {29'b0, dev_valid}, 32'h0);
    chk("rst_err_unmapped", {31'b0, err_unmapped}, 32'h0);
    chk("rst_err_timeout", {31'b0, err_timeout}, 32'h0);
    chk("rst_err_address", err_address, 32'h0);
    tick();
    reset = 1'b0;

    // RAM read, same-cycle completion
    valid = 1'b1; address = 32'h0000_0010; dev_ready = 3'b001;
    @(negedge clk);
    chk("ram_dev_valid", {29'b0, dev_valid}, 32'h1);
    chk("ram_ready", {31'b0, ready}, 32'h1);
    chk("ram_rdata", rdata, 32'hCAFE_0001);
    tick();
    valid = 1'b0; dev_ready = 3'b000;
    @(negedge clk);
    chk("idle_ready", {31'b0, ready}, 32'h0);
    chk("idle_dev_valid", {29'b0, dev_valid}, 32'h0);
    chk("idle_rdata", rdata, 32'h0);
    tick();

    // UART write, ready on 4th cycle
    valid = 1'b1; address = 32'h8100_0000; wdata = 32'h41; wstrobe = 4'hF;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) dev_ready = 3'b100;
      @(negedge clk);
      chk($sformatf("uart_dev_valid_c%0d", c), {29'b0, dev_valid}, 32'h4);
      chk($sformatf("uart_ready_c%0d", c), {31'b0, ready}, (c == 4) ? 32'h1 : 32'h0);
      chk($sformatf("uart_wdata_c%0d", c), dev_wdata, 32'h41);
      chk($sformatf("uart_wstrobe_c%0d", c), {28'b0, dev_wstrobe}, 32'hF);
      chk($sformatf("uart_address_c%0d", c), dev_address, 32'h8100_0000);
      tick();
    end
    valid = 1'b0; dev_ready = 3'b000; wstrobe = 4'h0; wdata = 32'h0;

    // Unmapped read
    valid = 1'b1; address = 32'h4000_0000;
    @(negedge clk);
    chk("unm_ready", {31'b0, ready}, 32'h1);
    chk("unm_rdata", rdata, 32'h0);
    chk("unm_dev_valid", {29'b0, dev_valid}, 32'h0);
    tick();
    valid = 1'b0;
    @(negedge clk);
    chk("unm_err_unmapped", {31'b0, err_unmapped}, 32'h1);
    chk("unm_err_address", err_address, 32'h4000_0000);
    chk("unm_err_timeout", {31'b0, err_timeout}, 32'h0);
    tick();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    @(negedge clk);
    chk("clr_err_unmapped", {31'b0, err_unmapped}, 32'h0);
    chk("clr_err_address", err_address, 32'h4000_0000);
    tick();

    // Back-to-back unmapped errors; second one coincides with err_clear
    valid = 1'b1; address = 32'h4000_0000;
    tick();
    address = 32'h5000_0000; err_clear = 1'b1;
    @(negedge clk);
    chk("b2b_first_err", {31'b0, err_unmapped}, 32'h1);
    tick();
    valid = 1'b0; err_clear = 1'b0;
    @(negedge clk);
    chk("b2b_err_unmapped", {31'b0, err_unmapped}, 32'h1);
    chk("b2b_err_address", err_address, 32'h5000_0000);
    tick();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;

    // Timer timeout after 4 counted BUSY cycles
    valid = 1'b1; address = 32'h8000_0004; dev_ready = 3'b000;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c < 5) begin
        chk($sformatf("to_dev_valid_c%0d", c), {29'b0, dev_valid}, 32'h2);
        chk($sformatf("to_ready_c%0d", c), {31'b0, ready}, 32'h0);
      end else begin
        chk("to_dev_valid_end", {29'b0, dev_valid}, 32'h0);
        chk("to_ready_end", {31'b0, ready}, 32'h1);
        chk("to_rdata_end", rdata, 32'h0);
      end
      tick();
    end
    valid = 1'b0;
    @(negedge clk);
    chk("to_err_timeout", {31'b0, err_timeout}, 32'h1);
    chk("to_err_address", err_address, 32'h8000_0004);
    chk("to_err_unmapped", {31'b0, err_unmapped}, 32'h0);
    tick();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    @(negedge clk);
    chk("to_clr_timeout", {31'b0, err_timeout}, 32'h0);
    chk("to_clr_address", err_address, 32'h8000_0004);
    tick();

    // dev_ready in the timeout cycle wins
    valid = 1'b1; address = 32'h8000_0004;
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) dev_ready = 3'b010;
      @(negedge clk);
      chk($sformatf("tr_ready_c%0d", c), {31'b0, ready}, (c == 5) ? 32'h1 : 32'h0);
      chk($sformatf("tr_dev_valid_c%0d", c), {29'b0, dev_valid}, 32'h2);
      tick();
    end
    chk("tr_rdata_dummy_free", 32'h0, {31'b0, err_timeout});
    valid = 1'b0; dev_ready = 3'b000;
    @(negedge clk);
    chk("tr_no_timeout", {31'b0, err_timeout}, 32'h0);
    tick();

    // Leave an error pending, then reset mid UART access
    valid = 1'b1; address = 32'h4000_0000;
    tick();
    address = 32'h8100_0000;
    tick();
    reset = 1'b1;
    @(negedge clk);
    tick();
    reset = 1'b0; valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", {31'b0, ready}, 32'h0);
    chk("mid_rst_dev_valid", {29'b0, dev_valid}, 32'h0);
    chk("mid_rst_err_unmapped", {31'b0, err_unmapped}, 32'h0);
    chk("mid_rst_err_timeout", {31'b0, err_timeout}, 32'h0);
    chk("mid_rst_err_address", err_address, 32'h0);
    tick();
    // IDLE uses live decode, BUSY on UART would not route to RAM
    valid = 1'b1; address = 32'h0000_0010; dev_ready = 3'b001;
    @(negedge clk);
    chk("post_rst_dev_valid", {29'b0, dev_valid}, 32'h1);
    chk("post_rst_ready", {31'b0, ready}, 32'h1);
    tick();
    valid = 1'b0; dev_ready = 3'b000;

    // IRQ masking
    dev_irq = 3'b111;
    #1 chk("irq_111", {31'b0, irq}, 32'h1);
    dev_irq = 3'b101;
    #1 chk("irq_101", {31'b0, irq}, 32'h0);
    dev_irq = 3'b010;
    #1 chk("irq_010", {31'b0, irq}, 32'h1);
    dev_irq = 3'b000;
    tick();

    // Duplicate tags resolve to lowest index
    valid = 1'b1; address = 32'h0000_0000; dev_ready = 3'b001;
    @(negedge clk);
    chk("dup_dev_valid", {29'b0, d_dev_valid}, 32'h1);
    chk("dup_rdata", d_rdata, 32'hCAFE_0001);
    tick();
    address = 32'h8000_0000; dev_ready = 3'b010;
    @(negedge clk);
    chk("dup_dev1_valid", {29'b0, d_dev_valid}, 32'h2);
    tick();
    valid = 1'b0; dev_ready = 3'b000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
